// File: rtl/motor_pwm_ramp.sv
// Multi-channel motor PWM with slew-limited duty ramp, safe direction
// reversal through zero duty and per-channel brake on a shared period.
module motor_pwm_ramp #(
    parameter int CLK_HZ = 100_000_000,
    parameter int PWM_HZ = 25_000,
    parameter int CH     = 2,
    parameter int DUTY_W = 10,
    parameter int STEP   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic [CH*DUTY_W-1:0] target_duty,
    input  logic [CH-1:0]        dir_cmd,
    input  logic [CH-1:0]        brake,
    output logic [CH-1:0]        pwm,
    output logic [CH-1:0]        dir,
    output logic [CH*DUTY_W-1:0] cur_duty,
    output logic                 period_tick,
    output logic [CH-1:0]        settled
);

    localparam int PERIOD = CLK_HZ / PWM_HZ;
    localparam int CW     = $clog2(PERIOD + 1);
    localparam int PW     = CW + DUTY_W;
    localparam int RW     = DUTY_W + 1;

    localparam logic [RW-1:0] STEP_R   = RW'(STEP);
    localparam logic [PW-1:0] PERIOD_P = PW'(PERIOD);
    localparam logic [CW-1:0] LAST     = CW'(PERIOD - 1);

    logic [CW-1:0]     count;
    logic [CW-1:0]     count_nxt;
    logic              boundary;
    logic [CW-1:0]     thr      [CH];
    logic [CW-1:0]     thr_nxt  [CH];
    logic [PW-1:0]     prod     [CH];
    logic [RW-1:0]     cur_x    [CH];
    logic [RW-1:0]     tgt_x    [CH];
    logic [RW-1:0]     ramp     [CH];
    logic [CH-1:0]     dir_nxt;
    logic [CH-1:0]     settled_nxt;

    assign boundary = en && (count == LAST);

    always_comb begin
        count_nxt   = (count == LAST) ? '0 : count + CW'(1);
        dir_nxt     = dir;
        settled_nxt = '0;
        for (int i = 0; i < CH; i++) begin
            cur_x[i]   = {1'b0, cur_duty[i*DUTY_W +: DUTY_W]};
            tgt_x[i]   = {1'b0, target_duty[i*DUTY_W +: DUTY_W]};
            prod[i]    = PERIOD_P * PW'(cur_duty[i*DUTY_W +: DUTY_W]);
            thr_nxt[i] = prod[i][PW-1:DUTY_W];
            ramp[i]    = cur_x[i];
            settled_nxt[i] = (cur_x[i] == tgt_x[i]) &&
                             (dir[i] == dir_cmd[i]) && !brake[i];
            // Reversal: bleed duty to zero before the direction may flip
            if (dir_cmd[i] != dir[i]) begin
                if (cur_x[i] != '0)
                    ramp[i] = (cur_x[i] > STEP_R) ? cur_x[i] - STEP_R : '0;
                else
                    dir_nxt[i] = dir_cmd[i];
            end else if (tgt_x[i] > cur_x[i]) begin
                ramp[i] = (cur_x[i] + STEP_R > tgt_x[i]) ?
                          tgt_x[i] : cur_x[i] + STEP_R;
            end else if (tgt_x[i] < cur_x[i]) begin
                ramp[i] = (cur_x[i] > tgt_x[i] + STEP_R) ?
                          cur_x[i] - STEP_R : tgt_x[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count       <= '0;
            period_tick <= 1'b0;
            pwm         <= '0;
            dir         <= '1;
            cur_duty    <= '0;
            settled     <= '0;
            for (int i = 0; i < CH; i++)
                thr[i] <= '0;
        end else begin
            settled <= settled_nxt;
            if (!en) begin
                count       <= '0;
                period_tick <= 1'b0;
                pwm         <= '0;
                cur_duty    <= '0;
                for (int i = 0; i < CH; i++)
                    thr[i] <= '0;
            end else begin
                count       <= count_nxt;
                period_tick <= (count_nxt == LAST);
                for (int i = 0; i < CH; i++) begin
                    if (brake[i]) begin
                        pwm[i]                      <= 1'b0;
                        cur_duty[i*DUTY_W +: DUTY_W] <= '0;
                        thr[i]                      <= '0;
                    end else begin
                        pwm[i] <= (count < thr[i]);
                        // Threshold takes the pre-update duty at the boundary
                        if (boundary) begin
                            thr[i]                      <= thr_nxt[i];
                            cur_duty[i*DUTY_W +: DUTY_W] <= ramp[i][DUTY_W-1:0];
                            dir[i]                      <= dir_nxt[i];
                        end
                    end
                end
            end
        end
    end

endmodule
